// File: rtl/if_fetch_unit.sv
// ============================================================================
// if_fetch_unit : credit-limited instruction fetch with in-flight PC tracking
// Revision 1.0
// ============================================================================
`default_nettype none

module if_fetch_unit #(
   parameter int DEPTH   = 2,
   parameter int ADDR_W  = 32,
   parameter int INSTR_W = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [ADDR_W-1:0]  PC,
   input  logic               flush,
   output logic               PC_Write_Final,
   output logic               imem_req_valid,
   output logic [ADDR_W-1:0]  imem_req_addr,
   input  logic               imem_req_ready,
   input  logic               imem_resp_valid,
   input  logic [INSTR_W-1:0] imem_resp_data,
   output logic               id_valid,
   output logic [ADDR_W-1:0]  id_pc,
   output logic [INSTR_W-1:0] id_instr,
   input  logic               id_ready
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W:0] LIMIT = (CNT_W + 1)'(DEPTH);

   logic               run;
   logic [CNT_W-1:0]   outstanding;
   logic [CNT_W-1:0]   discard;
   logic [CNT_W-1:0]   fifo_count;
   logic [ADDR_W-1:0]  pcq [DEPTH];
   logic [PTR_W-1:0]   pcq_rd;
   logic [PTR_W-1:0]   pcq_wr;
   logic [ADDR_W-1:0]  fifo_pc [DEPTH];
   logic [INSTR_W-1:0] fifo_instr [DEPTH];
   logic [PTR_W-1:0]   fifo_rd;
   logic [PTR_W-1:0]   fifo_wr;

   logic               flush_eff;
   logic               accept;
   logic               resp;
   logic               push;
   logic               pop;
   logic [CNT_W:0]     credit_used;

   // Flush is only meaningful once the unit is running, so reset keeps all outputs low.
   assign flush_eff      = flush & run;
   assign credit_used    = {1'b0, outstanding} + {1'b0, fifo_count};
   assign imem_req_valid = run & ~flush & (credit_used < LIMIT);
   assign imem_req_addr  = {PC[ADDR_W-1:2], 2'b00};
   assign accept         = imem_req_valid & imem_req_ready;
   assign PC_Write_Final = accept | flush_eff;

   // A response with nothing outstanding is a protocol error and is ignored.
   assign resp     = imem_resp_valid & (outstanding != '0);
   assign id_valid = (fifo_count != '0);
   assign id_pc    = fifo_pc[fifo_rd];
   assign id_instr = fifo_instr[fifo_rd];
   assign push     = resp & (discard == '0) & ~flush_eff;
   assign pop      = id_valid & id_ready & ~flush_eff;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         run         <= 1'b0;
         outstanding <= '0;
         discard     <= '0;
         fifo_count  <= '0;
         pcq_rd      <= '0;
         pcq_wr      <= '0;
         fifo_rd     <= '0;
         fifo_wr     <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            pcq[i]        <= '0;
            fifo_pc[i]    <= '0;
            fifo_instr[i] <= '0;
         end
      end else begin
         run <= 1'b1;

         if (accept) begin
            pcq[pcq_wr] <= PC;
            pcq_wr      <= pcq_wr + 1'b1;
         end
         if (resp) begin
            pcq_rd <= pcq_rd + 1'b1;
         end
         outstanding <= outstanding + CNT_W'(accept) - CNT_W'(resp);

         if (flush_eff) begin
            // Every response still in flight after this cycle must be dropped.
            fifo_count <= '0;
            fifo_rd    <= '0;
            fifo_wr    <= '0;
            discard    <= outstanding - CNT_W'(resp);
         end else begin
            if (resp && (discard != '0)) begin
               discard <= discard - 1'b1;
            end
            if (push) begin
               fifo_pc[fifo_wr]    <= pcq[pcq_rd];
               fifo_instr[fifo_wr] <= imem_resp_data;
               fifo_wr             <= fifo_wr + 1'b1;
            end
            if (pop) begin
               fifo_rd <= fifo_rd + 1'b1;
            end
            fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
// ============================================================================
// tb_if_fetch_unit : directed + randomized check against a queue-based model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_if_fetch_unit;

   localparam int DEPTH = 4;
   localparam int AW    = 32;
   localparam int IW    = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [AW-1:0] PC = '0;
   logic          flush = 1'b0;
   logic          PC_Write_Final;
   logic          imem_req_valid;
   logic [AW-1:0] imem_req_addr;
   logic          imem_req_ready = 1'b0;
   logic          imem_resp_valid = 1'b0;
   logic [IW-1:0] imem_resp_data = '0;
   logic          id_valid;
   logic [AW-1:0] id_pc;
   logic [IW-1:0] id_instr;
   logic          id_ready = 1'b0;

   always #5 clk = ~clk;

   if_fetch_unit #(.DEPTH(DEPTH), .ADDR_W(AW), .INSTR_W(IW)) dut (
      .clk             (clk),
      .rst             (rst),
      .PC              (PC),
      .flush           (flush),
      .PC_Write_Final  (PC_Write_Final),
      .imem_req_valid  (imem_req_valid),
      .imem_req_addr   (imem_req_addr),
      .imem_req_ready  (imem_req_ready),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .id_valid        (id_valid),
      .id_pc           (id_pc),
      .id_instr        (id_instr),
      .id_ready        (id_ready)
   );

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   // Reference model: fetches in flight, entries waiting for decode, responses to drop.
   bit                   m_run;
   logic [AW-1:0]        m_inflight[$];
   logic [AW+IW-1:0]     m_fifo[$];
   int                   m_discard;
   logic [AW-1:0]        pc_reg;

   typedef struct {
      logic [AW-1:0] addr;
      int            due;
   } mreq_t;
   mreq_t mem_q[$];

   function automatic logic [IW-1:0] instr_of(logic [AW-1:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h00C0_FFEE;
   endfunction

   task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic model_clear();
      m_run = 1'b0;
      m_inflight.delete();
      m_fifo.delete();
      m_discard = 0;
      mem_q.delete();
   endtask

   // One clock cycle: drive inputs, compare outputs, advance model and PC register.
   task automatic step(bit f, bit rdy, bit idr, int lat, logic [AW-1:0] target, bit stray);
      logic [IW-1:0] data;
      logic [AW-1:0] p;
      bit            rv, exp_rv, acc, fl, resp;
      rv   = 1'b0;
      data = '0;
      if (stray) begin
         rv   = 1'b1;
         data = 32'hDEAD_BEEF;
      end else if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
         rv   = 1'b1;
         data = instr_of(mem_q[0].addr);
         void'(mem_q.pop_front());
      end
      flush           = f;
      imem_req_ready  = rdy;
      id_ready        = idr;
      PC              = pc_reg;
      imem_resp_valid = rv;
      imem_resp_data  = data;
      #1;
      fl     = f & m_run;
      exp_rv = m_run && !f && (m_inflight.size() + m_fifo.size() < DEPTH);
      acc    = exp_rv & rdy;
      check("req_valid", 64'(imem_req_valid), 64'(exp_rv));
      if (exp_rv) check("req_addr", 64'(imem_req_addr), 64'({pc_reg[AW-1:2], 2'b00}));
      check("pc_write", 64'(PC_Write_Final), 64'(acc | fl));
      check("id_valid", 64'(id_valid), 64'(m_fifo.size() != 0));
      if (m_fifo.size() != 0) check("id_entry", {id_pc, id_instr}, m_fifo[0]);

      if (acc) mem_q.push_back('{pc_reg, cyc + lat});
      resp = rv && (m_inflight.size() != 0);
      if (fl) begin
         if (resp) void'(m_inflight.pop_front());
         m_fifo.delete();
         m_discard = m_inflight.size();
      end else begin
         if (m_fifo.size() != 0 && idr) void'(m_fifo.pop_front());
         if (resp) begin
            p = m_inflight.pop_front();
            if (m_discard > 0) m_discard--;
            else m_fifo.push_back({p, data});
         end
      end
      if (acc) m_inflight.push_back(pc_reg);
      assert (m_inflight.size() + m_fifo.size() <= DEPTH)
      else begin
         fails++;
         $error("FAIL credit_bound observed=%0d expected<=%0d", m_inflight.size() + m_fifo.size(), DEPTH);
      end
      m_run = 1'b1;
      if (acc | fl) pc_reg = fl ? target : pc_reg + 32'd4;
      @(posedge clk);
      cyc++;
      #1;
   endtask

   task automatic do_reset(int n);
      rst = 1'b0;
      model_clear();
      for (int i = 0; i < n; i++) begin
         flush           = 1'($urandom);
         imem_req_ready  = 1'($urandom);
         imem_resp_valid = 1'($urandom);
         imem_resp_data  = $urandom;
         id_ready        = 1'($urandom);
         PC              = $urandom;
         #1;
         check("rst_req_valid", 64'(imem_req_valid), 64'(0));
         check("rst_pc_write", 64'(PC_Write_Final), 64'(0));
         check("rst_id_valid", 64'(id_valid), 64'(0));
         check("rst_id_entry", {id_pc, id_instr}, 64'(0));
         @(posedge clk);
         cyc++;
         #1;
      end
      rst             = 1'b1;
      flush           = 1'b0;
      imem_resp_valid = 1'b0;
      pc_reg          = '0;
   endtask

   initial begin
      @(posedge clk);
      #1;
      // Reset with random inputs, then streaming with a 1-cycle memory.
      do_reset(4);
      for (int i = 0; i < 20; i++) step(0, 1, 1, 1, 0, 0);
      // Decode backpressure, then drain.
      for (int i = 0; i < 8; i++) step(0, 1, 0, 1, 0, 0);
      for (int i = 0; i < 10; i++) step(0, 1, 1, 1, 0, 0);
      // Memory stall.
      for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 0, 0);
      for (int i = 0; i < 6; i++) step(0, 1, 1, 1, 0, 0);
      // Slow memory with entries buffered, then redirect to 0x100.
      for (int i = 0; i < 4; i++) step(0, 1, 0, 3, 0, 0);
      step(1, 1, 1, 3, 32'h100, 0);
      for (int i = 0; i < 12; i++) step(0, 1, 1, 3, 0, 0);
      // Flush coinciding with a response and an id_ready pop.
      for (int i = 0; i < 6; i++) step(0, 1, 1, 1, 0, 0);
      step(1, 1, 1, 1, 32'h200, 0);
      for (int i = 0; i < 8; i++) step(0, 1, 1, 1, 0, 0);
      // Reset mid-stream, then a stray response after release.
      do_reset(2);
      step(0, 1, 1, 1, 0, 1);
      step(0, 1, 1, 1, 0, 1);
      for (int i = 0; i < 8; i++) step(0, 1, 1, 1, 0, 0);
      // Randomized traffic.
      for (int i = 0; i < 2000; i++) begin
         step(($urandom_range(0, 15) == 0), 1'($urandom), ($urandom_range(0, 3) != 0),
              $urandom_range(1, 4), $urandom & 32'hFFFF_FFFC, 0);
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
